// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use hazard detection.
// Captures decoded operands and control, inserts a bubble and stalls decode
// when the instruction in EX is a load whose destination the decode
// instruction reads, and honours branch flush and downstream hold.
// Optional feature: define STALL_COUNT_EN to add a 32-bit stall_count output
// that counts inserted load-use bubbles.
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int RAW    = 5,
    parameter int ALUOPW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [RAW-1:0]    id_rs1,
    input  logic [RAW-1:0]    id_rs2,
    input  logic [RAW-1:0]    id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic [ALUOPW-1:0] id_alu_op,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [XLEN-1:0]   id_pc,
    input  logic              flush,
    input  logic              ex_hold,
    output logic              stall_id,
    output logic              ex_valid,
    output logic [RAW-1:0]    ex_rs1,
    output logic [RAW-1:0]    ex_rs2,
    output logic [RAW-1:0]    ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic [ALUOPW-1:0] ex_alu_op,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_pc
`ifdef STALL_COUNT_EN
    ,
    output logic [31:0]       stall_count
`endif
);

    logic              r_valid;
    logic [RAW-1:0]    r_rs1;
    logic [RAW-1:0]    r_rs2;
    logic [RAW-1:0]    r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_memwrite;
    logic [ALUOPW-1:0] r_alu_op;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_pc;

    logic w_load_use;
    logic w_bubble;
    logic w_rd_nonzero;

    // A load in EX whose (non-x0) destination is read by a real decode
    // instruction: its data is not available until after MEM.
    assign w_load_use = r_valid & r_memread & (r_rd != '0) & id_valid
                      & ((r_rd == id_rs1) | (r_rd == id_rs2));

    // Flush takes precedence over the hazard: the decode slot is squashed
    // anyway, so there is nothing to retry.
    assign stall_id     = ex_hold | (w_load_use & ~flush);
    assign w_bubble     = flush | w_load_use;
    assign w_rd_nonzero = (id_rd != '0);

    // Pipeline register: reset, then hold, then bubble, otherwise load.
    // NOTE: sequential state uses <= so every register samples pre-edge values;
    // blocking = here would let later statements see already-updated state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_alu_op   <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= '0;
        end else if (!ex_hold) begin
            // Payload fields always follow decode; in a bubble they are
            // don't-care because all control is cleared.
            r_rs1      <= id_rs1;
            r_rs2      <= id_rs2;
            r_rd       <= id_rd;
            r_alu_op   <= id_alu_op;
            r_rs1_data <= id_rs1_data;
            r_rs2_data <= id_rs2_data;
            r_imm      <= id_imm;
            r_pc       <= id_pc;
            if (w_bubble) begin
                r_valid    <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
            end else begin
                // Gate control by valid, and never advertise a write to x0.
                r_valid    <= id_valid;
                r_regwrite <= id_valid & id_regwrite & w_rd_nonzero;
                r_memread  <= id_valid & id_memread;
                r_memwrite <= id_valid & id_memwrite;
            end
        end
    end

    assign ex_valid    = r_valid;
    assign ex_rs1      = r_rs1;
    assign ex_rs2      = r_rs2;
    assign ex_rd       = r_rd;
    assign ex_regwrite = r_regwrite;
    assign ex_memread  = r_memread;
    assign ex_memwrite = r_memwrite;
    assign ex_alu_op   = r_alu_op;
    assign ex_rs1_data = r_rs1_data;
    assign ex_rs2_data = r_rs2_data;
    assign ex_imm      = r_imm;
    assign ex_pc       = r_pc;

`ifdef STALL_COUNT_EN
    logic [31:0] r_stall_count;

    // Count only load-use bubbles that are actually inserted (not held,
    // not flushed); wraps naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (!ex_hold && !flush && w_load_use) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed scenarios followed by
// randomized traffic, checked against an instruction-level reference model.
module tb_id_ex_stage_reg;

    localparam int XLEN   = 32;
    localparam int RAW    = 5;
    localparam int ALUOPW = 4;

    typedef struct packed {
        logic              valid;
        logic [RAW-1:0]    rs1;
        logic [RAW-1:0]    rs2;
        logic [RAW-1:0]    rd;
        logic              regwrite;
        logic              memread;
        logic              memwrite;
        logic [ALUOPW-1:0] alu_op;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [XLEN-1:0]   pc;
    } slot_t;

    typedef struct packed {
        logic  rst_n;
        logic  flush;
        logic  hold;
        slot_t id;
    } stim_t;

    typedef enum logic [1:0] {ACT_RESET, ACT_HOLD, ACT_BUBBLE, ACT_LOAD} act_e;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [RAW-1:0]    id_rs1, id_rs2, id_rd;
    logic              id_regwrite, id_memread, id_memwrite;
    logic [ALUOPW-1:0] id_alu_op;
    logic [XLEN-1:0]   id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic              flush, ex_hold;
    logic              stall_id;
    logic              ex_valid;
    logic [RAW-1:0]    ex_rs1, ex_rs2, ex_rd;
    logic              ex_regwrite, ex_memread, ex_memwrite;
    logic [ALUOPW-1:0] ex_alu_op;
    logic [XLEN-1:0]   ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;
`ifdef STALL_COUNT_EN
    logic [31:0]       stall_count;
    logic [31:0]       model_count;
`endif

    int    tests = 0;
    int    fails = 0;
    slot_t model_ex;

    id_ex_stage_reg #(.XLEN(XLEN), .RAW(RAW), .ALUOPW(ALUOPW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
        .id_alu_op(id_alu_op), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_pc(id_pc), .flush(flush), .ex_hold(ex_hold),
        .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_alu_op(ex_alu_op), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_imm(ex_imm), .ex_pc(ex_pc)
`ifdef STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Does the decode instruction read a register that the load in EX has
    // not produced yet?
    function automatic logic needs_load_data(slot_t ex, slot_t id);
        if (!(ex.valid && ex.memread) || ex.rd == 0 || !id.valid) return 1'b0;
        return (id.rs1 == ex.rd) || (id.rs2 == ex.rd);
    endfunction

    function automatic act_e choose(slot_t ex, stim_t s);
        if (!s.rst_n) return ACT_RESET;
        if (s.hold) return ACT_HOLD;
        if (s.flush || needs_load_data(ex, s.id)) return ACT_BUBBLE;
        return ACT_LOAD;
    endfunction

    function automatic logic expect_stall(slot_t ex, stim_t s);
        return s.hold || (needs_load_data(ex, s.id) && !s.flush);
    endfunction

    function automatic slot_t advance(slot_t ex, stim_t s);
        slot_t n = s.id;
        case (choose(ex, s))
            ACT_RESET: n = '0;
            ACT_HOLD:  n = ex;
            ACT_BUBBLE: begin
                n.valid = 0; n.regwrite = 0; n.memread = 0; n.memwrite = 0;
            end
            default: begin
                if (!s.id.valid) begin
                    n.regwrite = 0; n.memread = 0; n.memwrite = 0;
                end
                if (s.id.rd == 0) n.regwrite = 0;
            end
        endcase
        return n;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t observed();
        return {ex_valid, ex_rs1, ex_rs2, ex_rd, ex_regwrite, ex_memread, ex_memwrite,
                ex_alu_op, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc};
    endfunction

    function automatic stim_t idle();
        stim_t s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    function automatic stim_t instr(input int rs1, input int rs2, input int rd,
                                    input logic rw, input logic mr, input logic [XLEN-1:0] pc);
        stim_t s = idle();
        s.id.valid    = 1'b1;
        s.id.rs1      = RAW'(rs1);
        s.id.rs2      = RAW'(rs2);
        s.id.rd       = RAW'(rd);
        s.id.regwrite = rw;
        s.id.memread  = mr;
        s.id.alu_op   = ALUOPW'(pc[5:2]);
        s.id.rs1_data = 32'h1000_0000 + pc;
        s.id.rs2_data = 32'h2000_0000 + pc;
        s.id.imm      = 32'hFFFF_0000 | pc;
        s.id.pc       = pc;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst_n       = s.rst_n;       flush       = s.flush;      ex_hold     = s.hold;
        id_valid    = s.id.valid;    id_rs1      = s.id.rs1;     id_rs2      = s.id.rs2;
        id_rd       = s.id.rd;       id_regwrite = s.id.regwrite;
        id_memread  = s.id.memread;  id_memwrite = s.id.memwrite;
        id_alu_op   = s.id.alu_op;   id_rs1_data = s.id.rs1_data;
        id_rs2_data = s.id.rs2_data; id_imm      = s.id.imm;     id_pc       = s.id.pc;
    endtask

    // One cycle: drive after the falling edge, check stall_id before the
    // rising edge, then check the registered state just after it.
    task automatic step(input string tag, input stim_t s);
        @(negedge clk);
        apply(s);
        #1;
        check({tag, "/stall_id"}, 256'(stall_id), 256'(expect_stall(model_ex, s)));
`ifdef STALL_COUNT_EN
        if (choose(model_ex, s) == ACT_RESET) model_count = 0;
        else if (choose(model_ex, s) == ACT_BUBBLE && !s.flush) model_count = model_count + 1;
`endif
        model_ex = advance(model_ex, s);
        @(posedge clk);
        #1;
        check({tag, "/ex"}, 256'(observed()), 256'(model_ex));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        stim_t s;
        model_ex = '0;
`ifdef STALL_COUNT_EN
        model_count = 0;
`endif
        apply(idle());

        // 1. Reset with every input driven non-zero.
        s = '1;
        s.rst_n = 1'b0;
        step("reset", s);
        check("reset/valid", 256'(ex_valid), 256'(0));
        check("reset/pc", 256'(ex_pc), 256'(0));

        // 2. Pass-through of a plain ALU instruction.
        step("pass", instr(3, 4, 5, 1'b1, 1'b0, 32'h40));
        check("pass/rd", 256'(ex_rd), 256'(5));
        check("pass/regwrite", 256'(ex_regwrite), 256'(1));
        check("pass/pc", 256'(ex_pc), 256'(32'h40));
        check("pass/valid", 256'(ex_valid), 256'(1));

        // 3. lw x3 followed by add x4,x3,x5: one bubble, then the add proceeds.
        step("lu_load", instr(1, 2, 3, 1'b1, 1'b1, 32'h44));
        step("lu_bubble", instr(3, 5, 4, 1'b1, 1'b0, 32'h48));
        check("lu_bubble/stall", 256'(stall_id), 256'(0));
        check("lu_bubble/valid", 256'(ex_valid), 256'(0));
        check("lu_bubble/regwrite", 256'(ex_regwrite), 256'(0));
        step("lu_retry", instr(3, 5, 4, 1'b1, 1'b0, 32'h48));
        check("lu_retry/rd", 256'(ex_rd), 256'(4));
        check("lu_retry/valid", 256'(ex_valid), 256'(1));

        // 4. lw x0 never stalls; rd=0 never advertises a write.
        step("x0_load", instr(1, 2, 0, 1'b1, 1'b1, 32'h4C));
        step("x0_use", instr(0, 0, 0, 1'b1, 1'b0, 32'h50));
        check("x0_use/regwrite", 256'(ex_regwrite), 256'(0));

        // 5. Priority: flush beats load-use, hold beats flush, reset beats hold.
        step("pri_load", instr(1, 2, 6, 1'b1, 1'b1, 32'h54));
        s = instr(6, 1, 7, 1'b1, 1'b0, 32'h58);
        s.flush = 1'b1;
        step("pri_flush", s);
        check("pri_flush/valid", 256'(ex_valid), 256'(0));
        step("pri_load2", instr(1, 2, 6, 1'b1, 1'b1, 32'h5C));
        s = instr(9, 10, 11, 1'b1, 1'b0, 32'h60);
        s.flush = 1'b1;
        s.hold  = 1'b1;
        step("pri_hold", s);
        check("pri_hold/pc", 256'(ex_pc), 256'(32'h5C));
        s.rst_n = 1'b0;
        step("pri_reset", s);
        check("pri_reset/valid", 256'(ex_valid), 256'(0));
        step("post_reset", instr(1, 2, 3, 1'b1, 1'b1, 32'h64));

`ifdef STALL_COUNT_EN
        // 6. Three load-use bubbles plus two flushes from a cleared counter.
        s = idle();
        s.rst_n = 1'b0;
        step("cnt_reset", s);
        for (int k = 0; k < 3; k++) begin
            step("cnt_load", instr(1, 2, 8, 1'b1, 1'b1, 32'h100));
            step("cnt_bubble", instr(8, 2, 9, 1'b1, 1'b0, 32'h104));
            s = instr(1, 2, 3, 1'b1, 1'b0, 32'h108);
            if (k < 2) s.flush = 1'b1;
            step("cnt_flush", s);
        end
        check("cnt/three", 256'(stall_count), 256'(3));
        @(negedge clk);
        force dut.r_stall_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_stall_count;
        model_count = 32'hFFFF_FFFF;
        step("wrap_load", instr(1, 2, 8, 1'b1, 1'b1, 32'h10C));
        step("wrap_bubble", instr(2, 8, 9, 1'b1, 1'b0, 32'h110));
        check("cnt/wrap", 256'(stall_count), 256'(0));
`endif

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.rst_n       = ($urandom_range(0, 31) != 0);
            s.flush       = ($urandom_range(0, 7) == 0);
            s.hold        = ($urandom_range(0, 7) == 0);
            s.id.valid    = ($urandom_range(0, 4) != 0);
            s.id.rs1      = RAW'($urandom_range(0, 3));
            s.id.rs2      = RAW'($urandom_range(0, 3));
            s.id.rd       = RAW'($urandom_range(0, 3));
            s.id.regwrite = 1'($urandom);
            s.id.memread  = 1'($urandom);
            s.id.memwrite = 1'($urandom);
            s.id.alu_op   = ALUOPW'($urandom);
            s.id.rs1_data = $urandom;
            s.id.rs2_data = $urandom;
            s.id.imm      = $urandom;
            s.id.pc       = $urandom;
            step("rand", s);
`ifdef STALL_COUNT_EN
            check("rand/count", 256'(stall_count), 256'(model_count));
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
